// File: rtl/armleosoc_timebase_pkg.sv
// Shared constants and helpers for the mtime timebase: register offsets, CTRL bits, ID.
package armleosoc_timebase_pkg;

  localparam int unsigned TB_DATA_W = 32;
  localparam int unsigned TB_OFFS_W = 5;
  localparam int unsigned TB_BE_W   = 4;

  localparam logic [TB_OFFS_W-1:0] TB_CTRL  = 5'h00;
  localparam logic [TB_OFFS_W-1:0] TB_STEP  = 5'h04;
  localparam logic [TB_OFFS_W-1:0] TB_PHASE = 5'h08;
  localparam logic [TB_OFFS_W-1:0] TB_TICKS = 5'h0C;
  localparam logic [TB_OFFS_W-1:0] TB_ID    = 5'h10;

  localparam int unsigned CTRL_EN  = 0;
  localparam int unsigned CTRL_SRC = 1;
  localparam int unsigned CTRL_W   = 2;

  localparam logic [TB_DATA_W-1:0] TB_ID_VALUE = 32'h5442_0001;

  // Byte-lane merge of a bus write into an existing register value.
  function automatic logic [TB_DATA_W-1:0] be_merge(
    input logic [TB_DATA_W-1:0] old_val,
    input logic [TB_DATA_W-1:0] wdata,
    input logic [TB_BE_W-1:0]   be
  );
    logic [TB_DATA_W-1:0] merged;
    merged = old_val;
    for (int i = 0; i < int'(TB_BE_W); i++) begin
      if (be[i]) merged[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/armleosoc_sync_edge.sv
// Multi-flop synchroniser for an asynchronous input followed by a rising-edge detector.
module armleosoc_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_c
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    edge_d = sync_q[SYNC_STAGES-1];
    rise_c = sync_q[SYNC_STAGES-1] & ~edge_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      edge_q <= edge_d;
    end
  end

endmodule

// File: rtl/armleosoc_timebase.sv
// mtime_increment pulse generator: NCO phase accumulator or synchronised external RTC tick,
// configured through a simple register bus.
module armleosoc_timebase
  import armleosoc_timebase_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_EN    = 1'b1,
  parameter logic [31:0] RESET_STEP  = 32'h0100_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  write,
  input  logic                  read,
  input  logic [31:0]           write_data,
  input  logic [3:0]            write_byteenable,
  output logic [31:0]           read_data,
  output logic                  address_error,
  output logic                  write_error,
  input  logic                  rtc_tick,
  output logic                  mtime_increment
);

  logic [CTRL_W-1:0]    ctrl_q, ctrl_d;
  logic [TB_DATA_W-1:0] step_q, step_d;
  logic [TB_DATA_W-1:0] phase_q, phase_d;
  logic [TB_DATA_W-1:0] ticks_q, ticks_d;
  logic                 inc_q, inc_d;

  logic [TB_OFFS_W-1:0] offset_c;
  logic                 wr_c;
  logic                 nco_en_c, ext_en_c;
  logic [TB_DATA_W:0]   sum_c;
  logic [TB_DATA_W-1:0] ctrl_wr_c;
  logic                 rise_c;
  logic                 unused_ok;

  assign unused_ok = ^{read, address[ADDR_WIDTH-1:5], address[1:0]};

  armleosoc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_rtc_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (rtc_tick),
    .rise_c   (rise_c)
  );

  // Register decode and combinational read path.
  always_comb begin
    offset_c      = {address[4:2], 2'b00};
    address_error = 1'b0;
    read_data     = '0;
    case (offset_c)
      TB_CTRL:  read_data = {{(TB_DATA_W-CTRL_W){1'b0}}, ctrl_q};
      TB_STEP:  read_data = step_q;
      TB_PHASE: read_data = phase_q;
      TB_TICKS: read_data = ticks_q;
      TB_ID:    read_data = TB_ID_VALUE;
      default:  address_error = 1'b1;
    endcase
    write_error = write & (offset_c == TB_ID);
    wr_c        = write & ~address_error;
  end

  // Next-state: register writes, NCO accumulate, source mux and tick counter.
  always_comb begin
    ctrl_d    = ctrl_q;
    step_d    = step_q;
    phase_d   = phase_q;
    ticks_d   = ticks_q;
    inc_d     = 1'b0;
    nco_en_c  = ctrl_q[CTRL_EN] & ~ctrl_q[CTRL_SRC];
    ext_en_c  = ctrl_q[CTRL_EN] & ctrl_q[CTRL_SRC];
    sum_c     = {1'b0, phase_q} + {1'b0, step_q};
    ctrl_wr_c = be_merge({{(TB_DATA_W-CTRL_W){1'b0}}, ctrl_q}, write_data, write_byteenable);

    if (nco_en_c) begin
      phase_d = sum_c[TB_DATA_W-1:0];
      inc_d   = sum_c[TB_DATA_W];
    end else if (ext_en_c) begin
      inc_d = rise_c;
    end

    if (inc_q) ticks_d = ticks_q + 32'd1;

    if (wr_c) begin
      case (offset_c)
        TB_CTRL:  ctrl_d = ctrl_wr_c[CTRL_W-1:0];
        TB_STEP:  step_d = be_merge(step_q, write_data, write_byteenable);
        TB_PHASE: begin
          phase_d = be_merge(phase_q, write_data, write_byteenable);
          if (nco_en_c) inc_d = 1'b0;
        end
        TB_TICKS: ticks_d = be_merge(ticks_q, write_data, write_byteenable);
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= {1'b0, RESET_EN};
      step_q  <= RESET_STEP;
      phase_q <= '0;
      ticks_q <= '0;
      inc_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      step_q  <= step_d;
      phase_q <= phase_d;
      ticks_q <= ticks_d;
      inc_q   <= inc_d;
    end
  end

  assign mtime_increment = inc_q;

endmodule
